// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: LSU FSM states, funct3 access codes
// and the load/store major opcodes.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, sign/zero extension for loads, and the
// access legality check (size encoding and natural alignment).
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [31:0] byte_sh_s;
  logic [31:0] half_sh_s;

  // Lane steering, extension and legality decode
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    illegal    = is_load & is_store;
    byte_sh_s  = rdata >> {offset, 3'b000};
    half_sh_s  = rdata >> {offset[1], 4'b0000};
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
      end
      F3_H: begin
        be         = 4'b0011 << {offset[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sh_s[15]}}, half_sh_s[15:0]};
        illegal    = illegal | offset[0];
      end
      F3_W: begin
        illegal = illegal | (offset != 2'b00);
      end
      F3_BU: begin
        rdata_ext = {24'h00_0000, byte_sh_s[7:0]};
        illegal   = illegal | is_store;
      end
      F3_HU: begin
        rdata_ext = {16'h0000, half_sh_s[15:0]};
        illegal   = illegal | is_store | offset[0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    // Loads always fetch the full word; lanes are picked on the way back
    if (!is_store) begin
      be = 4'b1111;
    end else begin
      be = be;
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Memory-stage load/store unit: issues one valid/ready request per load or
// store, stalls the pipeline while it is in flight, and returns the result.
module lsu_mem_port
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [3:0]        req_be_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_rdata_i
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  lsu_state_e        state_r;
  lsu_state_e        next_state_s;
  logic [7:0]        cnt_r;
  logic [7:0]        cnt_inc_s;
  logic              op_s;
  logic              illegal_s;
  logic              err_next_s;
  logic [3:0]        be_s;
  logic [DATA_W-1:0] wdata_lane_s;
  logic [DATA_W-1:0] rdata_ext_s;
  logic [DATA_W-1:0] rdata_next_s;

  lsu_align u_align (
    .funct3     (funct3_i),
    .offset     (addr_i[1:0]),
    .is_load    (mem_read_i),
    .is_store   (mem_write_i),
    .wdata      (wdata_i),
    .rdata      (rsp_rdata_i),
    .be         (be_s),
    .wdata_lane (wdata_lane_s),
    .rdata_ext  (rdata_ext_s),
    .illegal    (illegal_s)
  );

  // Stall is combinational so the pipeline freezes in the accept cycle
  always_comb begin
    op_s    = mem_read_i | mem_write_i;
    stall_o = op_s & (state_r != DONE) & ~rst;
  end

  // Next-state decode; a completing handshake wins over a same-cycle timeout
  always_comb begin
    next_state_s = state_r;
    err_next_s   = 1'b0;
    rdata_next_s = {DATA_W{1'b0}};
    cnt_inc_s    = cnt_r + 8'd1;
    case (state_r)
      IDLE: begin
        if (op_s && illegal_s) begin
          next_state_s = DONE;
          err_next_s   = 1'b1;
        end else if (op_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (req_ready_i) begin
          next_state_s = mem_write_i ? DONE : WAIT_RSP;
        end else if (cnt_inc_s == TMO) begin
          next_state_s = DONE;
          err_next_s   = 1'b1;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid_i) begin
          next_state_s = DONE;
          rdata_next_s = rdata_ext_s;
        end else if (cnt_inc_s == TMO) begin
          next_state_s = DONE;
          err_next_s   = 1'b1;
        end else begin
          next_state_s = WAIT_RSP;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, timeout counter and registered port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= {DATA_W{1'b0}};
      req_valid_o <= 1'b0;
      req_we_o    <= 1'b0;
      req_addr_o  <= {ADDR_W{1'b0}};
      req_be_o    <= 4'b0000;
      req_wdata_o <= {DATA_W{1'b0}};
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= ((state_r == REQ) || (state_r == WAIT_RSP)) ? cnt_inc_s : 8'd0;
      done_o      <= (next_state_s == DONE);
      err_o       <= err_next_s;
      rdata_o     <= rdata_next_s;
      req_valid_o <= (next_state_s == REQ);
      if (next_state_s == REQ) begin
        req_we_o    <= mem_write_i;
        req_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
        req_be_o    <= be_s;
        req_wdata_o <= wdata_lane_s;
      end else begin
        req_we_o    <= 1'b0;
        req_addr_o  <= {ADDR_W{1'b0}};
        req_be_o    <= 4'b0000;
        req_wdata_o <= {DATA_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: drives ops on the falling edge, plays
// the memory side by hand and checks every observation against constants.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        req_valid_o, req_ready_i, req_we_o;
  logic [31:0] req_addr_o, req_wdata_o;
  logic [3:0]  req_be_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_rdata_i;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_we_o(req_we_o),
    .req_addr_o(req_addr_o), .req_be_o(req_be_o), .req_wdata_o(req_wdata_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    funct3_i    = 3'b000;
    addr_i      = 32'h0;
    wdata_i     = 32'h0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_rdata_i = 32'h0;
  endtask

  // One op from accept to DONE; memory waits ready_dly cycles of valid, then rsp_dly cycles
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ready_dly, input int rsp_dly, input logic [31:0] word,
                        input logic exp_req, input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        output int cycles);
    int phase = 0;
    int rv = 0;
    int wc = 0;
    logic seen = 1'b0;
    mem_read_i  = rd;
    mem_write_i = wr;
    funct3_i    = f3;
    addr_i      = addr;
    wdata_i     = wdata;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_rdata_i = word;
    #1;
    check({tag, ".stall_accept"}, {31'd0, stall_o}, 32'd1);
    cycles = 0;
    while (cycles < 40) begin
      tick();
      cycles++;
      if (done_o) break;
      check({tag, ".stall"}, {31'd0, stall_o}, 32'd1);
      if (req_valid_o) begin
        seen  = 1'b1;
        phase = 1;
        rv++;
        check({tag, ".addr"}, req_addr_o, addr & 32'hFFFF_FFFC);
        check({tag, ".be"}, {28'd0, req_be_o}, {28'd0, exp_be});
        check({tag, ".we"}, {31'd0, req_we_o}, {31'd0, wr});
        if (wr) check({tag, ".wdata"}, req_wdata_o, exp_wdata);
        req_ready_i = (rv > ready_dly);
      end else if (phase != 0) begin
        phase       = 2;
        req_ready_i = 1'b0;
        wc++;
        rsp_valid_i = (wc > rsp_dly);
      end
    end
    check({tag, ".done"}, {31'd0, done_o}, 32'd1);
    check({tag, ".err"}, {31'd0, err_o}, {31'd0, exp_err});
    check({tag, ".rdata"}, rdata_o, exp_rdata);
    check({tag, ".stall_done"}, {31'd0, stall_o}, 32'd0);
    check({tag, ".valid_done"}, {31'd0, req_valid_o}, 32'd0);
    check({tag, ".req_seen"}, {31'd0, seen}, {31'd0, exp_req});
    idle_inputs();
    tick();
    check({tag, ".done_pulse"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst.stall", {31'd0, stall_o}, 32'd0);
    check("rst.done", {31'd0, done_o}, 32'd0);
    check("rst.valid", {31'd0, req_valid_o}, 32'd0);
    check("rst.rdata", rdata_o, 32'd0);
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'h1111_2222;
    tick();
    check("idle_rsp_ignored", {31'd0, done_o}, 32'd0);
    rsp_valid_i = 1'b0;

    run_op("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0,
           1'b1, 1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF, lat);
    check("sw.lat", lat, 32'd2);
    run_op("lb", 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 1, 32'h80FF_0000,
           1'b1, 1'b0, 32'hFFFF_FF80, 4'b1111, 32'h0, lat);
    check("lb.lat", lat, 32'd4);
    run_op("lbu", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 1, 32'h80FF_0000,
           1'b1, 1'b0, 32'h0000_0080, 4'b1111, 32'h0, lat);
    run_op("lh", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 0, 32'h80FF_0000,
           1'b1, 1'b0, 32'hFFFF_80FF, 4'b1111, 32'h0, lat);
    check("lh.lat", lat, 32'd3);
    run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1, 0, 32'h80FF_0000,
           1'b1, 1'b0, 32'h0000_80FF, 4'b1111, 32'h0, lat);
    run_op("lw", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 0, 2, 32'h1234_5678,
           1'b1, 1'b0, 32'h1234_5678, 4'b1111, 32'h0, lat);
    run_op("sh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 4, 0, 32'h0,
           1'b1, 1'b0, 32'h0, 4'b1100, 32'h1234_1234, lat);
    check("sh.lat", lat, 32'd6);
    run_op("sb", 1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 0, 0, 32'h0,
           1'b1, 1'b0, 32'h0, 4'b0010, 32'hA5A5_A5A5, lat);
    run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'hFFFF_FFFF,
           1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, lat);
    check("lw_mis.lat", lat, 32'd1);
    run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h203, 32'h0, 0, 0, 32'hFFFF_FFFF,
           1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, lat);
    run_op("sbu_ill", 1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0,
           1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, lat);
    run_op("ld_ill", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0,
           1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, lat);
    run_op("rw_ill", 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0,
           1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, lat);
    run_op("tmo_rsp", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 1000, 32'hAAAA_5555,
           1'b1, 1'b1, 32'h0, 4'b1111, 32'h0, lat);
    check("tmo_rsp.lat", lat, 32'd9);
    run_op("tmo_rdy", 1'b0, 1'b1, 3'b010, 32'h300, 32'h0BAD_F00D, 1000, 0, 32'h0,
           1'b1, 1'b1, 32'h0, 4'b1111, 32'h0BAD_F00D, lat);
    check("tmo_rdy.lat", lat, 32'd9);

    // Reset while waiting for read data: everything clears, late data is dropped
    mem_read_i = 1'b1;
    funct3_i   = 3'b010;
    addr_i     = 32'h300;
    tick();
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check("rstw.in_wait", {30'd0, req_valid_o, stall_o}, 32'd1);
    rst        = 1'b1;
    mem_read_i = 1'b0;
    tick();
    check("rstw.stall", {31'd0, stall_o}, 32'd0);
    check("rstw.outs", {28'd0, done_o, err_o, req_valid_o, req_we_o}, 32'd0);
    check("rstw.rdata", rdata_o, 32'd0);
    check("rstw.addr", req_addr_o, 32'd0);
    check("rstw.be", {28'd0, req_be_o}, 32'd0);
    check("rstw.wdata", req_wdata_o, 32'd0);
    rst         = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'hCAFE_F00D;
    tick();
    check("rstw.late1", {31'd0, done_o}, 32'd0);
    tick();
    check("rstw.late2", {30'd0, done_o, req_valid_o}, 32'd0);
    rsp_valid_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
